// File: rtl/bbff_bank_scheduler.sv
// rtl/bbff_bank_scheduler.sv - round-robin scheduler applying {B1,B2} commands to a shared bank of command flip-flop cells
module bbff_bank_scheduler #(
    parameter int NREQ  = 4,
    parameter int NCELL = 8,
    parameter int AW    = 3,
    localparam int GW   = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [2*NREQ-1:0]    cmd_i,
    input  logic [AW*NREQ-1:0]   addr_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [GW-1:0]        grant_id_o,
    output logic [NCELL-1:0]     q_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, APPLY, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NCELL-1:0]  cell_q, cell_d;
    logic              busy_q, busy_d;

    // Requests rotated so that bit 0 is the requester at the round-robin pointer.
    logic [2*NREQ-1:0] req_rot;
    logic              found;
    logic [GW:0]       sel_sum;
    logic              req_gnt;

    // Next cell state for {B1,B2}: 00 hold, 01 clear, 10 toggle, 11 set.
    function automatic logic cell_next(input logic qv, input logic [1:0] c);
        return (~qv & c[1]) | (c[1] & c[0]) | (qv & ~c[1] & ~c[0]);
    endfunction

    // State register and all datapath registers; async reset clears outputs mid-transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            ack_q   <= '0;
            cell_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            cell_q  <= cell_d;
            busy_q  <= busy_d;
        end
    end

    // Arbitration, command application and handshake sequencing.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        ack_d   = ack_q;
        cell_d  = cell_q;
        found   = 1'b0;
        sel_sum = '0;
        req_gnt = 1'b0;
        req_rot = {req_i, req_i} >> ptr_q;

        case (state_q)
            IDLE: begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req_rot[k]) begin
                        found   = 1'b1;
                        sel_sum = {1'b0, ptr_q} + (GW+1)'(k);
                        if (sel_sum >= (GW+1)'(NREQ)) begin
                            sel_sum = sel_sum - (GW+1)'(NREQ);
                        end
                    end
                end
                if (found) begin
                    grant_d = sel_sum[GW-1:0];
                    state_d = APPLY;
                    // Command and address are captured here; later changes are ignored.
                    for (int j = 0; j < NREQ; j++) begin
                        if (sel_sum[GW-1:0] == GW'(j)) begin
                            cmd_d  = cmd_i[2*j +: 2];
                            addr_d = addr_i[AW*j +: AW];
                        end
                    end
                end
            end
            APPLY: begin
                // Out-of-range addresses match no cell, so the bank is untouched.
                for (int c = 0; c < NCELL; c++) begin
                    if (addr_q == AW'(c)) begin
                        cell_d[c] = cell_next(cell_q[c], cmd_q);
                    end
                end
                for (int j = 0; j < NREQ; j++) begin
                    ack_d[j] = (grant_q == GW'(j));
                end
                state_d = RELEASE;
            end
            RELEASE: begin
                for (int j = 0; j < NREQ; j++) begin
                    if (grant_q == GW'(j)) begin
                        req_gnt = req_i[j];
                    end
                end
                if (!req_gnt) begin
                    ack_d   = '0;
                    ptr_d   = (grant_q == GW'(NREQ-1)) ? '0 : grant_q + GW'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign ack_o      = ack_q;
    assign grant_id_o = grant_q;
    assign q_o        = cell_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_bbff_bank_scheduler.sv
// tb/tb_bbff_bank_scheduler.sv - directed self-checking bench for bbff_bank_scheduler
module tb_bbff_bank_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  cmd;
    logic [11:0] addr;

    logic [3:0]  ack, ack6;
    logic [1:0]  gid, gid6;
    logic [7:0]  q;
    logic [5:0]  q6;
    logic        busy, busy6;

    int vectors = 0;
    int miscompares = 0;

    bbff_bank_scheduler #(.NREQ(4), .NCELL(8), .AW(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .cmd_i(cmd), .addr_i(addr),
        .ack_o(ack), .grant_id_o(gid), .q_o(q), .busy_o(busy)
    );

    bbff_bank_scheduler #(.NREQ(4), .NCELL(6), .AW(3)) dut6 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .cmd_i(cmd), .addr_i(addr),
        .ack_o(ack6), .grant_id_o(gid6), .q_o(q6), .busy_o(busy6)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        req   = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; cmd = '0; addr = '0;
        step(); step();
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack got %b want %b", ack, 4'b0000); end
        vectors++; if (q !== 8'h00) begin miscompares++; $display("FAIL reset_q got %h want %h", q, 8'h00); end
        vectors++; if (gid !== 2'd0) begin miscompares++; $display("FAIL reset_gid got %0d want %0d", gid, 0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want %b", busy, 1'b0); end
        rst_n = 1'b1;
        step();
        // Drive requester 1 into RELEASE, then reset asynchronously.
        req = 4'b0010; cmd[3:2] = 2'b11; addr[5:3] = 3'd0;
        step();
        step();
        vectors++; if (ack !== 4'b0010) begin miscompares++; $display("FAIL pre_reset_ack got %b want %b", ack, 4'b0010); end
        vectors++; if (q !== 8'h01) begin miscompares++; $display("FAIL pre_reset_q got %h want %h", q, 8'h01); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL async_reset_ack got %b want %b", ack, 4'b0000); end
        vectors++; if (q !== 8'h00) begin miscompares++; $display("FAIL async_reset_q got %h want %h", q, 8'h00); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_reset_busy got %b want %b", busy, 1'b0); end
        vectors++; if (q6 !== 6'h00) begin miscompares++; $display("FAIL async_reset_q6 got %h want %h", q6, 6'h00); end
        step();
        rst_n = 1'b1;
        // ptr must be 0: requesters 1 and 3 pending, 1 wins.
        req = 4'b1010; cmd = '0; addr = '0;
        step();
        vectors++; if (gid !== 2'd1) begin miscompares++; $display("FAIL ptr_after_reset_gid got %0d want %0d", gid, 1); end
        step();
        vectors++; if (ack !== 4'b0010) begin miscompares++; $display("FAIL ptr_after_reset_ack got %b want %b", ack, 4'b0010); end
        req = 4'b1000;
        step();
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL release1_ack got %b want %b", ack, 4'b0000); end
        step();
        vectors++; if (gid !== 2'd3) begin miscompares++; $display("FAIL second_grant_gid got %0d want %0d", gid, 3); end
        step();
        vectors++; if (ack !== 4'b1000) begin miscompares++; $display("FAIL second_grant_ack got %b want %b", ack, 4'b1000); end
        req = 4'b0000;
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL release3_busy got %b want %b", busy, 1'b0); end
        vectors++; if (q !== 8'h00) begin miscompares++; $display("FAIL hold_q got %h want %h", q, 8'h00); end
    endtask

    task automatic test_cmd_sweep();
        logic [1:0] cmds [5];
        logic       expq [5];
        cmds = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b00};
        expq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            req = 4'b0001; cmd[1:0] = cmds[i]; addr[2:0] = 3'd3;
            step();
            vectors++; if (gid !== 2'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL sweep%0d_grant got gid=%0d busy=%b want gid=0 busy=1", i, gid, busy); end
            vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL sweep%0d_ack_early got %b want %b", i, ack, 4'b0000); end
            step();
            vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL sweep%0d_ack got %b want %b", i, ack, 4'b0001); end
            vectors++; if (q[3] !== expq[i]) begin miscompares++; $display("FAIL sweep%0d_q3 got %b want %b", i, q[3], expq[i]); end
            req = 4'b0000;
            step();
            vectors++; if (ack !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("FAIL sweep%0d_release got ack=%b busy=%b want ack=0000 busy=0", i, ack, busy); end
        end
    endtask

    task automatic test_all_four();
        pulse_reset();
        cmd  = 8'b10101010;
        addr = {3'd3, 3'd2, 3'd1, 3'd0};
        req  = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++; if (gid !== 2'(k)) begin miscompares++; $display("FAIL all4_grant%0d got %0d want %0d", k, gid, k); end
            step();
            vectors++; if (ack !== (4'b0001 << k)) begin miscompares++; $display("FAIL all4_ack%0d got %b want %b", k, ack, 4'b0001 << k); end
            req[k] = 1'b0;
            step();
            vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL all4_release%0d got %b want %b", k, ack, 4'b0000); end
        end
        vectors++; if (q !== 8'h0F) begin miscompares++; $display("FAIL all4_q got %h want %h", q, 8'h0F); end
        vectors++; if (q6 !== 6'h0F) begin miscompares++; $display("FAIL all4_q6 got %h want %h", q6, 6'h0F); end
    endtask

    task automatic test_fairness();
        int order [4];
        order = '{0, 2, 0, 2};
        pulse_reset();
        cmd = '0; addr = '0;
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++; if (gid !== 2'(order[k])) begin miscompares++; $display("FAIL fair_grant%0d got %0d want %0d", k, gid, order[k]); end
            step();
            vectors++; if (ack !== (4'b0001 << order[k])) begin miscompares++; $display("FAIL fair_ack%0d got %b want %b", k, ack, 4'b0001 << order[k]); end
            req[order[k]] = 1'b0;
            step();
            vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL fair_release%0d got %b want %b", k, ack, 4'b0000); end
            req[order[k]] = 1'b1;
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_same_cell();
        pulse_reset();
        cmd = '0; addr = '0;
        cmd[3:2] = 2'b11; addr[5:3] = 3'd5;
        cmd[5:4] = 2'b10; addr[8:6] = 3'd5;
        req = 4'b0110;
        step();
        vectors++; if (gid !== 2'd1) begin miscompares++; $display("FAIL same_first_gid got %0d want %0d", gid, 1); end
        step();
        vectors++; if (ack !== 4'b0010 || q !== 8'h20) begin miscompares++; $display("FAIL same_set got ack=%b q=%h want ack=0010 q=20", ack, q); end
        req = 4'b0100;
        step();
        step();
        vectors++; if (gid !== 2'd2) begin miscompares++; $display("FAIL same_second_gid got %0d want %0d", gid, 2); end
        step();
        vectors++; if (ack !== 4'b0100 || q !== 8'h00) begin miscompares++; $display("FAIL same_toggle got ack=%b q=%h want ack=0100 q=00", ack, q); end
        req = 4'b0000;
        step();
        vectors++; if (busy !== 1'b0 || q6 !== 6'h00) begin miscompares++; $display("FAIL same_end got busy=%b q6=%h want busy=0 q6=00", busy, q6); end
    endtask

    task automatic test_early_drop();
        pulse_reset();
        cmd = '0; addr = '0;
        cmd[7:6] = 2'b11; addr[11:9] = 3'd2;
        req = 4'b1000;
        step();
        vectors++; if (gid6 !== 2'd3) begin miscompares++; $display("FAIL drop_gid got %0d want %0d", gid6, 3); end
        req = 4'b0000;
        step();
        vectors++; if (ack6 !== 4'b1000 || q6 !== 6'h04) begin miscompares++; $display("FAIL drop_apply got ack=%b q6=%h want ack=1000 q6=04", ack6, q6); end
        step();
        vectors++; if (ack6 !== 4'b0000 || busy6 !== 1'b0) begin miscompares++; $display("FAIL drop_release got ack=%b busy=%b want ack=0000 busy=0", ack6, busy6); end
        addr[11:9] = 3'd7;
        req = 4'b1000;
        step();
        vectors++; if (gid6 !== 2'd3 || busy6 !== 1'b1) begin miscompares++; $display("FAIL badaddr_grant got gid=%0d busy=%b want gid=3 busy=1", gid6, busy6); end
        step();
        vectors++; if (ack6 !== 4'b1000) begin miscompares++; $display("FAIL badaddr_ack got %b want %b", ack6, 4'b1000); end
        vectors++; if (q6 !== 6'h04) begin miscompares++; $display("FAIL badaddr_q6 got %h want %h", q6, 6'h04); end
        vectors++; if (q !== 8'h84) begin miscompares++; $display("FAIL addr7_q8 got %h want %h", q, 8'h84); end
        req = 4'b0000;
        step();
        vectors++; if (ack6 !== 4'b0000 || busy6 !== 1'b0) begin miscompares++; $display("FAIL badaddr_release got ack=%b busy=%b want ack=0000 busy=0", ack6, busy6); end
    endtask

    initial begin
        test_reset();
        test_cmd_sweep();
        test_all_four();
        test_fairness();
        test_same_cell();
        test_early_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bbff_bank_scheduler.md
# bbff_bank_scheduler

Shares a bank of NCELL two-input command flip-flop cells (hold/clear/toggle/set, next state `(~Q&B1)|(B1&B2)|(Q&~B1&~B2)`) between NREQ requesters. A round-robin arbiter grants one requester at a time. A small FSM applies the latched {B1,B2} command to the addressed cell and closes a four-phase req/ack handshake. The block sits between the control agents and the cell bank, and is the only writer of the bank.

## Interface
- NREQ, 4, number of requesters (2..8)
- NCELL, 8, number of cells in the bank (1..2**AW)
- AW, 3, cell address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request, level; held until ack seen
- cmd  in  2*NREQ  per-requester command {B1,B2}; requester i at bits [2i+1:2i]
- addr  in  AW*NREQ  per-requester cell address; requester i at bits [AW*i+AW-1:AW*i]
- ack  out  NREQ  per-requester acknowledge, one-hot or zero
- grant_id  out  clog2(NREQ)  index of the current/last winner
- q  out  NCELL  cell states, registered
- busy  out  1  high whenever FSM is not IDLE

## Operation
- Reset values: q=0, ack=0, grant_id=0, busy=0, FSM=IDLE, round-robin pointer ptr=0. Reset is asynchronous, so ack and q clear immediately, including mid-transaction.
- Command encoding {B1,B2}:
  - 00 hold
  - 01 clear (Q<=0)
  - 10 toggle
  - 11 set (Q<=1)
- FSM states:
  - IDLE: if any req bit is set, pick the first set bit scanning ptr, ptr+1, … (wrapping NREQ-1→0). Latch winner index into grant_id, and latch its cmd and addr into internal registers. Go to APPLY. Otherwise stay in IDLE.
  - APPLY: q[addr_l] <= f(q[addr_l], cmd_l); all other cells hold. Set ack[grant_id]<=1. Go to RELEASE.
  - RELEASE: hold ack. When req[grant_id]==0: ack<=0, ptr<=(grant_id+1) mod NREQ, go to IDLE.
- Command and address are latched in IDLE. Changes on cmd/addr after the grant edge have no effect.
- If a requester drops req before ack is asserted, the command is still applied and acked. RELEASE then exits on the next edge.
- If addr_l >= NCELL, no cell changes, but the handshake still completes normally.
- A hold command (00) still runs the full handshake.
- Simultaneous requests are serialized strictly by round-robin. No requester is granted twice while another holds req continuously.
- Multiple requesters targeting the same cell: commands apply in grant order. Each command sees the result of the previous one.
- Non-winning requests wait with no side effects. ack for non-winners stays 0.

## Timing
- req sampled high at edge E (FSM in IDLE) → grant_id and busy valid after E.
- Edge E+1: q updates and ack rises.
- ack falls on the first edge after req[grant_id] is sampled low. The FSM is back in IDLE on that same edge.
- The next grant happens no earlier than one edge later. Minimum transaction is 3 edges if the requester drops req the cycle after it sees ack.
- q is stable except at APPLY edges. At most one cell changes per transaction.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-RELEASE: rst_n low with ack[1]=1 → ack=0, q=0, busy=0 immediately (before the next clk); after release, ptr=0.
- Single requester, full command sweep on cell 3: set, toggle, toggle, clear, hold → q[3] sequence 1,0,1,0,0. Each ack rises exactly 1 edge after the grant edge.
- All four requesters request together from reset, each toggling a distinct cell 0..3 → grant order 0,1,2,3; final q=8'h0F.
- Fairness: req[0] and req[2] held continuously, re-asserting after each ack → grants alternate 0,2,0,2. ptr wraps from 3 to 0 when NREQ=4.
- Same-cell conflict: requester 1 sends set and requester 2 sends toggle, both to cell 5, both from idle, with ptr=0 → requester 1 wins first; final q[5]=0.
- Early drop plus invalid address, run with NCELL=6: req[3] pulsed for 1 cycle with cmd=11, addr=2 → q[2]=1, ack[3] high for exactly 1 cycle. A separate request with addr=7 → acked, q unchanged.
